// File: rtl/adaptive_demux_if.sv
// Upstream beat, per-channel downstream handshake and status for adaptive_demux.
// The slave modport is the demux side; master is the driver/consumer side.
interface adaptive_demux_if #(
  parameter int DW     = 3,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DW-1:0]     chan_en;
  logic [DW-1:0]     out_valid;
  logic [DATA_W-1:0] out_data;
  logic [DW-1:0]     out_ready;
  logic [DW-1:0]     sel_last;
  logic [DW*16-1:0]  chan_cnt;

  modport master (
    output in_valid, in_data, chan_en, out_ready,
    input  in_ready, out_valid, out_data, sel_last, chan_cnt
  );

  modport slave (
    input  in_valid, in_data, chan_en, out_ready,
    output in_ready, out_valid, out_data, sel_last, chan_cnt
  );
endinterface

// File: rtl/adaptive_demux.sv
// Single-buffer demux that steers each beat to one enabled channel (round-robin or sticky).
// Define ADAPTIVE_DEMUX_CNT_EN to build the per-channel 16-bit accepted-beat counters.
module adaptive_demux #(
  parameter int DW     = 3,
  parameter int DATA_W = 8,
  parameter int MODE   = 0
) (
  input logic             clk,
  input logic             rst,
  adaptive_demux_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] buf_data_q;
  logic [DW-1:0]     buf_sel_q;
  logic [DW-1:0]     sel_last_q;

  logic          drain;
  logic          xfer;
  logic [DW-1:0] tgt_d;
  logic [DW-1:0] rr_sel;
  logic [DW-1:0] low_sel;
  logic          rr_found;
  logic          low_found;
  int            last_idx;

  assign bus.out_valid = (state_q == FULL) ? buf_sel_q : '0;
  assign bus.out_data  = buf_data_q;
  assign bus.sel_last  = sel_last_q;

  assign drain        = (state_q == FULL) && (|(bus.out_valid & bus.out_ready));
  assign bus.in_ready = ((state_q == EMPTY) || drain) && (|bus.chan_en);
  assign xfer         = bus.in_valid && bus.in_ready;

  // Target channel: lowest enabled after reset, otherwise the next enabled one
  // after sel_last with wrap (sticky mode keeps sel_last while it stays enabled).
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    last_idx  = 0;
    low_sel   = '0;
    low_found = 1'b0;
    rr_sel    = '0;
    rr_found  = 1'b0;
    tgt_d     = '0;
    for (int i = 0; i < DW; i++) begin
      if (sel_last_q[i]) last_idx = i;
      if (!low_found && bus.chan_en[i]) begin
        low_sel[i] = 1'b1;
        low_found  = 1'b1;
      end
    end
    for (int k = 1; k <= DW; k++) begin
      if (!rr_found && bus.chan_en[(last_idx + k) % DW]) begin
        rr_sel[(last_idx + k) % DW] = 1'b1;
        rr_found                    = 1'b1;
      end
    end
    if (sel_last_q == '0)                                tgt_d = low_sel;
    else if ((MODE == 1) && (|(sel_last_q & bus.chan_en))) tgt_d = sel_last_q;
    else                                                 tgt_d = rr_sel;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      buf_data_q <= '0;
      buf_sel_q  <= '0;
      sel_last_q <= '0;
    end else if (xfer) begin
      state_q    <= FULL;
      buf_data_q <= bus.in_data;
      buf_sel_q  <= tgt_d;
      sel_last_q <= tgt_d;
    end else if (drain) begin
      state_q <= EMPTY;
    end
  end

`ifdef ADAPTIVE_DEMUX_CNT_EN
  logic [DW-1:0][15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (xfer) begin
      for (int i = 0; i < DW; i++) begin
        if (tgt_d[i]) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign bus.chan_cnt = cnt_q;
`else
  assign bus.chan_cnt = '0;
`endif

endmodule

// File: tb/tb_adaptive_demux.sv
// Directed bench for adaptive_demux: a MODE 0 and a MODE 1 instance, DW=4, DATA_W=8.
module tb_adaptive_demux;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  adaptive_demux_if #(.DW(4), .DATA_W(8)) bus0 ();
  adaptive_demux_if #(.DW(4), .DATA_W(8)) bus1 ();

  adaptive_demux #(.DW(4), .DATA_W(8), .MODE(0)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  adaptive_demux #(.DW(4), .DATA_W(8), .MODE(1)) u_sticky (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.in_valid  = 1'b0;
    bus0.in_data   = 8'h00;
    bus0.chan_en   = 4'hF;
    bus0.out_ready = 4'hF;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 8'h00;
    bus1.chan_en   = 4'hF;
    bus1.out_ready = 4'hF;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    checks++;
    if (bus0.out_valid !== 4'h0) begin
      failures++; $display("FAIL reset_out_valid got=%h exp=%h", bus0.out_valid, 4'h0);
    end
    checks++;
    if (bus0.out_data !== 8'h00) begin
      failures++; $display("FAIL reset_out_data got=%h exp=%h", bus0.out_data, 8'h00);
    end
    step();
    checks++;
    if (bus0.sel_last !== 4'h0) begin
      failures++; $display("FAIL reset_sel_last got=%h exp=%h", bus0.sel_last, 4'h0);
    end
    checks++;
    if (bus0.chan_cnt !== 64'h0) begin
      failures++; $display("FAIL reset_chan_cnt got=%h exp=%h", bus0.chan_cnt, 64'h0);
    end
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=%b", bus0.in_ready, 1'b1);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ov [8];
    exp_ov = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    bus0.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus0.in_data = 8'(8'h10 + i);
      #1;
      if (i == 0) begin
        checks++;
        if (bus0.out_valid !== 4'h0) begin
          failures++; $display("FAIL b2b_early_valid got=%h exp=%h", bus0.out_valid, 4'h0);
        end
      end
      checks++;
      if (bus0.in_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_in_ready beat=%0d got=%b exp=%b", i, bus0.in_ready, 1'b1);
      end
      step();
      checks++;
      if (bus0.out_valid !== exp_ov[i] || bus0.out_data !== 8'(8'h10 + i)) begin
        failures++;
        $display("FAIL b2b_beat%0d got=%h/%h exp=%h/%h", i, bus0.out_valid, bus0.out_data,
                 exp_ov[i], 8'(8'h10 + i));
      end
    end
    bus0.in_valid = 1'b0;
    step();
    checks++;
    if (bus0.out_valid !== 4'h0 || bus0.sel_last !== 4'h8) begin
      failures++;
      $display("FAIL b2b_drain got=%h/%h exp=%h/%h", bus0.out_valid, bus0.sel_last, 4'h0, 4'h8);
    end
  endtask

  task automatic test_skip_disabled();
    logic [3:0] exp_ov [3];
    exp_ov = '{4'h2, 4'h8, 4'h2};
    bus0.chan_en  = 4'b1010;
    bus0.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus0.in_data = 8'(8'h20 + i);
      step();
      checks++;
      if (bus0.out_valid !== exp_ov[i] || bus0.out_data !== 8'(8'h20 + i)) begin
        failures++;
        $display("FAIL skip_beat%0d got=%h/%h exp=%h/%h", i, bus0.out_valid, bus0.out_data,
                 exp_ov[i], 8'(8'h20 + i));
      end
    end
    bus0.in_valid = 1'b0;
    bus0.chan_en  = 4'hF;
    step();
  endtask

  task automatic test_sticky();
    logic [3:0] exp_ov [5];
    exp_ov = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2};
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus1.chan_en = 4'hE;
      bus1.in_data = 8'(8'h30 + i);
      step();
      checks++;
      if (bus1.out_valid !== exp_ov[i] || bus1.out_data !== 8'(8'h30 + i)) begin
        failures++;
        $display("FAIL sticky_beat%0d got=%h/%h exp=%h/%h", i, bus1.out_valid, bus1.out_data,
                 exp_ov[i], 8'(8'h30 + i));
      end
    end
    bus1.in_valid = 1'b0;
    bus1.chan_en  = 4'hF;
    step();
  endtask

  // sel_last is channel 1 on entry, so the first beat lands on channel 2
  task automatic test_hold();
    bus0.out_ready = 4'h0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 8'h40;
    step();
    bus0.in_data = 8'h41;
    bus0.chan_en = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus0.out_valid !== 4'b0100 || bus0.out_data !== 8'h40 || bus0.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%h/%h/%b exp=%h/%h/%b", c, bus0.out_valid,
                 bus0.out_data, bus0.in_ready, 4'b0100, 8'h40, 1'b0);
      end
      step();
    end
    bus0.out_ready = 4'b0100;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      failures++; $display("FAIL hold_drain_ready got=%b exp=%b", bus0.in_ready, 1'b1);
    end
    step();
    checks++;
    if (bus0.out_valid !== 4'b1000 || bus0.out_data !== 8'h41) begin
      failures++;
      $display("FAIL hold_reload got=%h/%h exp=%h/%h", bus0.out_valid, bus0.out_data, 4'b1000, 8'h41);
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 4'hF;
    bus0.chan_en   = 4'hF;
    step();
  endtask

  // sel_last is channel 3 on entry, so the first beat wraps to channel 0
  task automatic test_no_enable();
    bus0.out_ready = 4'h0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 8'h50;
    step();
    checks++;
    if (bus0.out_valid !== 4'h1 || bus0.sel_last !== 4'h1) begin
      failures++;
      $display("FAIL wrap_beat got=%h/%h exp=%h/%h", bus0.out_valid, bus0.sel_last, 4'h1, 4'h1);
    end
    bus0.chan_en   = 4'h0;
    bus0.in_data   = 8'h51;
    bus0.out_ready = 4'hF;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b0) begin
      failures++; $display("FAIL noen_ready_full got=%b exp=%b", bus0.in_ready, 1'b0);
    end
    step();
    checks++;
    if (bus0.out_valid !== 4'h0 || bus0.sel_last !== 4'h1) begin
      failures++;
      $display("FAIL noen_drain got=%h/%h exp=%h/%h", bus0.out_valid, bus0.sel_last, 4'h0, 4'h1);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 4'h0) begin
        failures++;
        $display("FAIL noen_idle%0d got=%b/%h exp=%b/%h", c, bus0.in_ready, bus0.out_valid, 1'b0, 4'h0);
      end
    end
    bus0.in_valid = 1'b0;
    bus0.chan_en  = 4'hF;
  endtask

  task automatic test_reset_mid();
    bus0.out_ready = 4'h0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 8'h60;
    step();
    checks++;
    if (bus0.out_valid !== 4'h2) begin
      failures++; $display("FAIL rstmid_full got=%h exp=%h", bus0.out_valid, 4'h2);
    end
    bus0.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus0.out_valid !== 4'h0 || bus0.sel_last !== 4'h0 || bus0.out_data !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_async got=%h/%h/%h exp=%h/%h/%h", bus0.out_valid, bus0.sel_last,
               bus0.out_data, 4'h0, 4'h0, 8'h00);
    end
    #2;
    rst            = 1'b0;
    bus0.out_ready = 4'hF;
    step();
    checks++;
    if (bus0.out_valid !== 4'h0) begin
      failures++; $display("FAIL rstmid_no_pulse got=%h exp=%h", bus0.out_valid, 4'h0);
    end
    bus0.chan_en  = 4'b0110;
    bus0.in_valid = 1'b1;
    bus0.in_data  = 8'h61;
    step();
    checks++;
    if (bus0.out_valid !== 4'h2 || bus0.out_data !== 8'h61) begin
      failures++;
      $display("FAIL rstmid_first got=%h/%h exp=%h/%h", bus0.out_valid, bus0.out_data, 4'h2, 8'h61);
    end
    bus0.in_valid = 1'b0;
    bus0.chan_en  = 4'hF;
    step();
  endtask

  task automatic test_counter();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    bus1.chan_en  = 4'h1;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'h70;
`ifdef ADAPTIVE_DEMUX_CNT_EN
    repeat (65537) @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    step();
    checks++;
    if (bus1.chan_cnt !== 64'h0000_0000_0000_0001) begin
      failures++;
      $display("FAIL cnt_wrap got=%h exp=%h", bus1.chan_cnt, 64'h0000_0000_0000_0001);
    end
`else
    repeat (10) @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    step();
    checks++;
    if (bus1.chan_cnt !== 64'h0 || bus0.chan_cnt !== 64'h0) begin
      failures++;
      $display("FAIL cnt_absent got=%h/%h exp=%h/%h", bus1.chan_cnt, bus0.chan_cnt, 64'h0, 64'h0);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_skip_disabled();
    test_sticky();
    test_hold();
    test_no_enable();
    test_reset_mid();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
